uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter that pulls bytes from the TX buffer through a request/valid handshake and serialises them on `tx`. Data width, stop-bit count, parity sense and baud divisor are configurable. Parity generation is optional at compile time. It drops in where the fixed 8N1 transmitter sits today, between the TX FIFO and the pad, on the single system clock.

## Interface
Parameters:
- `CLOCK_RATE`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate. DIV = CLOCK_RATE / BAUD_RATE (integer divide), DIV ≥ 2 required.
- `DATA_BITS`, default 8: payload bits per frame, legal 5..8.
- `STOP_BITS`, default 1: legal 1 or 2.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Only used with `UART_TX_PARITY_EN`.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `SYS_reset`, in, 1: synchronous reset, active-high.
- `buffer_empty`, in, 1: TX buffer holds no data.
- `data_in`, in, DATA_BITS: payload. Sampled only when `data_valid`=1 in LOAD.
- `data_valid`, in, 1: buffer read data valid. Must arrive exactly one cycle after `data_requesting`.
- `data_requesting`, out, 1: one-cycle buffer read strobe.
- `tx`, out, 1: serial line, registered, idles high.
- `txDone`, out, 1: one-cycle pulse when the last stop bit completes.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- Reset values: `tx`=1, `data_requesting`=0, `txDone`=0, `busy`=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- States: IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If `buffer_empty`=0, go to REQ. Otherwise stay.
- REQ: `data_requesting`=1 for exactly this cycle. Go to LOAD.
- LOAD: if `data_valid`=1, latch `data_in`, drive `tx`←0 and go to START. If `data_valid`=0, abandon the request and go to IDLE. No frame is sent and `tx` stays 1.
- START, DATA, PARITY and STOP each hold `tx` for exactly DIV cycles. The baud counter runs 0..DIV-1, and the next bit value is registered on the cycle the counter reaches DIV-1. The counter width is $clog2(DIV).
- DATA: sends DATA_BITS bits, LSB first. The bit index wraps to 0 on the last bit.
- PARITY: present only with the macro. The bit is the XOR of the latched payload, inverted when PARITY_ODD=1.
- STOP: `tx`=1 for STOP_BITS×DIV cycles.
  - On the final stop cycle, `txDone` pulses and the state returns to IDLE.
  - `tx` stays 1 throughout, so back-to-back frames show no glitch.
- `data_valid` outside LOAD is ignored. `buffer_empty` is only evaluated in IDLE.
- Reset mid-frame:
  - The frame aborts at the next edge and `tx`=1.
  - No `txDone` pulse. The latched data is discarded.

## Timing
- Request latency: `data_requesting` rises 1 cycle after IDLE sees `buffer_empty`=0.
- Handshake:
  - `data_requesting` high in cycle R.
  - `data_valid` and `data_in` must be driven in cycle R+1.
  - `tx` goes low in cycle R+2.
- Frame length: DIV × (1 + DATA_BITS + P + STOP_BITS) cycles, where P = 1 with the macro and 0 without.
- `txDone` is high in the last cycle of the stop period.
- Minimum gap between consecutive start-bit falling edges: frame length + 3 cycles (IDLE, REQ, LOAD).

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state and parity logic are compiled in.
  - One parity bit follows the data, with sense set by PARITY_ODD.
- Not defined:
  - No PARITY state and no parity logic.
  - DATA goes straight to STOP and PARITY_ODD is ignored.

## Test plan
- 8N1, DIV=16 (CLOCK_RATE=160, BAUD_RATE=10), byte 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. Frame is 160 cycles. One `txDone` pulse in cycle 160.
- Macro on, PARITY_ODD=0, byte 0xA5 → parity bit 0 and 176-cycle frame. Same byte with PARITY_ODD=1 → parity bit 1.
- DATA_BITS=7, STOP_BITS=2, byte 0x41 → start bit, then 1,0,0,0,0,0,1, then stop high for 32 cycles.
- `buffer_empty`=0 but `data_valid` withheld in LOAD → no frame and `tx` stays 1. A new `data_requesting` follows 2 cycles later.
- Two queued bytes 0x55 and 0x0F → two complete frames with start edges exactly frame length + 3 cycles apart.
- `SYS_reset` asserted in the middle of the third data bit → `tx`=1, `busy`=0 and `txDone`=0 from the next cycle. A following byte transmits normally.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: buffer-fed UART transmitter with configurable data/stop bits and baud divisor
// Ports:
//   clk             - system clock, rising edge
//   SYS_reset       - synchronous active-high reset
//   buffer_empty    - TX buffer has no data (looked at only while idle)
//   data_in         - payload, captured in LOAD when data_valid is high
//   data_valid      - buffer read data valid, one cycle after data_requesting
//   data_requesting - one-cycle buffer read strobe
//   tx              - registered serial line, idles high
//   txDone          - pulse in the last cycle of the stop period
//   busy            - high whenever the transmitter is not idle
// Define UART_TX_PARITY_EN to add a parity bit (sense set by PARITY_ODD).
module uart_tx_frame #(
    parameter int CLOCK_RATE = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 SYS_reset,
    input  logic                 buffer_empty,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_requesting,
    output logic                 tx,
    output logic                 txDone,
    output logic                 busy
);
    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    localparam int CW  = $clog2(DIV);

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx_frame: illegal parameter set");
    end

    // Every state after LOAD is a timed line bit.
    typedef enum logic [2:0] {
        IDLE, REQ, LOAD, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic            last_baud, last_bit, last_stop, bit_step, tail_bit, tx_d;

    always_comb begin
        last_baud = baud_cnt == CW'(DIV - 1);
        last_bit  = bit_cnt == 3'(DATA_BITS - 1);
        last_stop = bit_cnt == 3'(STOP_BITS - 1);
        bit_step  = (state == DATA || state == STOP) && last_baud;
`ifdef UART_TX_PARITY_EN
        // The shift register rotates, so its XOR is the payload parity at any point.
        tail_bit  = ^shreg ^ PARITY_ODD[0];
`else
        tail_bit  = 1'b1;
`endif
        // The next line value is registered on the final cycle of the current bit.
        tx_d = state == LOAD ? !data_valid :
               !last_baud    ? tx :
               state == START ? shreg[0] :
               state == DATA  ? (last_bit ? tail_bit : shreg[1]) : 1'b1;
    end

    always_ff @(posedge clk) begin
        state <= SYS_reset ? IDLE : state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:   state_d = buffer_empty ? IDLE : REQ;
            REQ:    state_d = LOAD;
            LOAD:   state_d = data_valid ? START : IDLE;
            START:  state_d = last_baud ? DATA : START;
`ifdef UART_TX_PARITY_EN
            DATA:   state_d = last_baud && last_bit ? PARITY : DATA;
            PARITY: state_d = last_baud ? STOP : PARITY;
`else
            DATA:   state_d = last_baud && last_bit ? STOP : DATA;
`endif
            STOP:   state_d = last_baud && last_stop ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_requesting = state == REQ;
        busy            = state != IDLE;
        txDone          = state == STOP && last_baud && last_stop;
    end

    always_ff @(posedge clk) begin
        if (SYS_reset) begin
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            tx       <= tx_d;
            baud_cnt <= state > LOAD && !last_baud ? baud_cnt + 1'b1 : '0;
            bit_cnt  <= !bit_step ? bit_cnt :
                        (state == DATA ? last_bit : last_stop) ? 3'd0 : bit_cnt + 3'd1;
            shreg    <= state == LOAD && data_valid ? data_in :
                        state == DATA && last_baud ? {shreg[0], shreg[DATA_BITS-1:1]} : shreg;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: checks an 8N1 and a 7-bit/2-stop transmitter against a frame-decoding scoreboard
module tb_uart_tx_frame;
    localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FLA = DIV * (1 + 8 + P + 1);
    localparam int FLB = DIV * (1 + 7 + P + 2);

    typedef struct {
        int         inst;
        logic [7:0] data;
        string      seq;
        logic       par;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, withhold = 1'b0;
    logic be_a = 1'b1, dv_a = 1'b0, req_a, tx_a, done_a, busy_a;
    logic be_b = 1'b1, dv_b = 1'b0, req_b, tx_b, done_b, busy_b;
    logic [7:0] din_a = '0;
    logic [6:0] din_b = '0;
    int cyc = 0, tests = 0, fails = 0, frames_a = 0, frames_b = 0, aborts = 0;
    int bq_a[$], bq_b[$], sb_a[$], sb_b[$], starts_a[$], starts_b[$];
    vec_t tab[$];

    uart_tx_frame #(.CLOCK_RATE(160), .BAUD_RATE(10), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
        .clk(clk), .SYS_reset(rst), .buffer_empty(be_a), .data_in(din_a), .data_valid(dv_a),
        .data_requesting(req_a), .tx(tx_a), .txDone(done_a), .busy(busy_a));

    uart_tx_frame #(.CLOCK_RATE(160), .BAUD_RATE(10), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) u_b (
        .clk(clk), .SYS_reset(rst), .buffer_empty(be_b), .data_in(din_b), .data_valid(dv_b),
        .data_requesting(req_b), .tx(tx_b), .txDone(done_b), .busy(busy_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input int inst, input logic [7:0] data, input string seq, input logic par);
        vec_t v;
        v.inst = inst;
        v.data = data;
        v.seq  = seq;
        v.par  = par;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_s(input string nm, input string act, input string exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %s, want %s", nm, act, exp);
        end
    endtask

    task automatic wait_frames(input int w, input int n, input int budget, input string nm);
        int c = 0;
        while ((w != 0 ? frames_b : frames_a) < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(nm, int'((w != 0 ? frames_b : frames_a) >= n), 1);
    endtask

    // Buffer model: answers each request with the next queued byte one cycle later.
    initial begin
        logic ra, rb;
        int i;
        forever begin
            @(negedge clk);
            ra = req_a;
            rb = req_b;
            @(posedge clk);
            #1;
            dv_a = 1'b0;
            dv_b = 1'b0;
            if (ra && !withhold && bq_a.size() > 0) begin
                i = bq_a.pop_front();
                dv_a = 1'b1;
                din_a = tab[i].data;
                sb_a.push_back(i);
            end
            if (rb && bq_b.size() > 0) begin
                i = bq_b.pop_front();
                dv_b = 1'b1;
                din_b = tab[i].data[6:0];
                sb_b.push_back(i);
            end
            be_a = bq_a.size() == 0;
            be_b = bq_b.size() == 0;
        end
    end

    // Line monitor: decodes one frame per falling start edge and compares it with the scoreboard.
    task automatic mon(input int w);
        int n, s, fl, glitch, dones, donepos, idx, ones;
        logic t, d, first;
        logic smp [0:15];
        bit ab;
        string got, nm;
        n  = w != 0 ? 7 : 8;
        s  = w != 0 ? 2 : 1;
        fl = w != 0 ? FLB : FLA;
        forever begin
            @(negedge clk);
            t = w != 0 ? tx_b : tx_a;
            d = w != 0 ? done_b : done_a;
            if (rst || t !== 1'b0) begin
                if (d === 1'b1 && !rst) chk(w != 0 ? "b stray_done" : "a stray_done", 1, 0);
                continue;
            end
            if (w != 0) starts_b.push_back(cyc); else starts_a.push_back(cyc);
            idx = -1;
            if (w != 0 && sb_b.size() > 0) idx = sb_b.pop_front();
            if (w == 0 && sb_a.size() > 0) idx = sb_a.pop_front();
            glitch = 0; dones = 0; donepos = -1; ab = 0; first = 1'b0;
            for (int k = 0; k < fl; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    t = w != 0 ? tx_b : tx_a;
                    d = w != 0 ? done_b : done_a;
                end
                if (rst) begin
                    ab = 1;
                    break;
                end
                if (k % DIV == 0) first = t;
                else if (t !== first) glitch++;
                if (k % DIV == DIV / 2) smp[k / DIV] = t;
                if (d === 1'b1) begin
                    dones++;
                    donepos = k;
                end
            end
            if (ab) begin
                aborts++;
                continue;
            end
            if (idx < 0) begin
                chk(w != 0 ? "b unexpected_frame" : "a unexpected_frame", 1, 0);
                continue;
            end
            nm = $sformatf("%s[%02h]", w != 0 ? "b" : "a", tab[idx].data);
            chk({nm, " start"}, int'(smp[0]), 0);
            got = "";
            for (int j = 1; j <= n; j++) got = {got, smp[j] ? "1" : "0"};
            chk_s({nm, " data"}, got, tab[idx].seq);
`ifdef UART_TX_PARITY_EN
            chk({nm, " parity"}, int'(smp[n + 1]), int'(tab[idx].par ^ (w != 0)));
`endif
            ones = 0;
            for (int j = 0; j < s; j++) ones += int'(smp[1 + n + P + j]);
            chk({nm, " stop"}, ones, s);
            chk({nm, " hold"}, glitch, 0);
            chk({nm, " done_cnt"}, dones, 1);
            chk({nm, " done_pos"}, donepos, fl - 1);
            if (w != 0) frames_b++; else frames_a++;
        end
    endtask

    initial mon(0);
    initial mon(1);

    initial begin
        #(30000 * 10);
        $display("FAIL watchdog: run exceeded 30000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r1, r2, n0, c, s;
        logic txhi;
        tab.push_back(mk(0, 8'hA5, "10100101", 1'b0));
        tab.push_back(mk(0, 8'h55, "10101010", 1'b0));
        tab.push_back(mk(0, 8'h0F, "11110000", 1'b0));
        tab.push_back(mk(0, 8'h00, "00000000", 1'b0));
        tab.push_back(mk(0, 8'hFF, "11111111", 1'b0));
        tab.push_back(mk(0, 8'h80, "00000001", 1'b1));
        tab.push_back(mk(0, 8'h01, "10000000", 1'b1));
        tab.push_back(mk(1, 8'h41, "1000001",  1'b0));
        tab.push_back(mk(1, 8'h7F, "1111111",  1'b1));
        tab.push_back(mk(1, 8'h2A, "0101010",  1'b1));
        tab.push_back(mk(0, 8'hC3, "11000011", 1'b0));
        tab.push_back(mk(0, 8'h96, "01101001", 1'b0));
        tab.push_back(mk(0, 8'h3C, "00111100", 1'b0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset tx_a", int'(tx_a), 1);
        chk("reset busy_a", int'(busy_a), 0);
        chk("reset req_a", int'(req_a), 0);
        chk("reset done_a", int'(done_a), 0);
        chk("reset tx_b", int'(tx_b), 1);
        chk("reset busy_b", int'(busy_b), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            if (tab[i].inst != 0) bq_b.push_back(i); else bq_a.push_back(i);
        wait_frames(0, 7, 3000, "batch_a complete");
        wait_frames(1, 3, 1000, "batch_b complete");
        if (starts_a.size() >= 7)
            for (int i = 1; i < 7; i++) chk($sformatf("a gap %0d", i), starts_a[i] - starts_a[i - 1], FLA + 3);
        if (starts_b.size() >= 3)
            for (int i = 1; i < 3; i++) chk($sformatf("b gap %0d", i), starts_b[i] - starts_b[i - 1], FLB + 3);

        withhold = 1'b1;
        n0 = starts_a.size();
        txhi = 1'b1;
        bq_a.push_back(10);
        r1 = -1; r2 = -1; c = 0;
        while (r1 < 0 && c < 50) begin
            @(negedge clk);
            c++;
            txhi &= tx_a & !done_a;
            if (req_a) r1 = cyc;
        end
        c = 0;
        while (r2 < 0 && c < 50) begin
            @(negedge clk);
            c++;
            txhi &= tx_a & !done_a;
            if (req_a) r2 = cyc;
        end
        chk("withheld req_seen", int'(r1 >= 0 && r2 >= 0), 1);
        chk("withheld req_gap", r2 - r1, 3);
        chk("withheld tx_idle", int'(txhi), 1);
        chk("withheld no_frame", starts_a.size(), n0);
        withhold = 1'b0;
        wait_frames(0, 8, 500, "after_withhold complete");

        n0 = starts_a.size();
        bq_a.push_back(11);
        c = 0;
        while (starts_a.size() == n0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("midreset frame_started", int'(starts_a.size() > n0), 1);
        s = starts_a[$];
        c = 0;
        while (cyc < s + 55 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("midreset busy_before", int'(busy_a), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset tx", int'(tx_a), 1);
        chk("midreset busy", int'(busy_a), 0);
        chk("midreset done", int'(done_a), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset aborts", aborts, 1);
        chk("midreset tx_after", int'(tx_a), 1);
        bq_a.push_back(12);
        wait_frames(0, 9, 500, "post_reset complete");
        chk("a scoreboard empty", sb_a.size(), 0);
        chk("b scoreboard empty", sb_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
